// File: rtl/spi_slave_fifo_pkg.sv
// Shared constants for the SPI slave: FSM state encodings and SPI mode selectors.
package spi_defs;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;

   localparam int CPOL_IDLE_LOW  = 0;
   localparam int CPOL_IDLE_HIGH = 1;
   localparam int CPHA_LEADING   = 0;
   localparam int CPHA_TRAILING  = 1;

endpackage

// File: rtl/spi_slave_fifo_fifo.sv
// Single-clock FIFO; full/empty come from an extra wrap bit on each pointer.
module sync_fifo
   import spi_defs::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_rd;
   logic             w_wr;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // A write into a full FIFO is accepted when a pop frees the slot in the same cycle.
   assign w_rd = i_rd_en && !o_empty;
   assign w_wr = i_wr_en && (!o_full || w_rd);

   assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI slave with TX/RX word FIFOs; SPI pins are oversampled in the i_clk domain.
module spi_slave_fifo
   import spi_defs::*;
#(
   parameter int WORD_BITS   = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
)(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [WORD_BITS-1:0] i_tx_data,
   input  logic                 i_tx_valid,
   output logic                 o_tx_ready,
   output logic [WORD_BITS-1:0] o_rx_data,
   output logic                 o_rx_valid,
   input  logic                 i_rx_ready,
   output logic                 o_busy,
   output logic                 o_tx_underrun,
   output logic                 o_rx_overflow,
   input  logic                 i_ssel_n,
   input  logic                 i_sck,
   input  logic                 i_mosi,
   output logic                 o_miso,
   output logic                 o_miso_oe,
   output logic [1:0]           o_dbg_state
);

   localparam int             CW       = $clog2(WORD_BITS);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(WORD_BITS - 1);
   localparam logic           SCK_IDLE = (CPOL == CPOL_IDLE_HIGH);

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_ssel_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sck_d;
   logic                   w_sck;
   logic                   w_ssel_n;
   logic                   w_mosi;
   logic                   w_rise;
   logic                   w_fall;
   logic                   w_lead;
   logic                   w_trail;
   logic                   w_sample_edge;
   logic                   w_shift_edge;
   logic                   w_wrap;
   logic                   w_load;

   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic [CW-1:0]          r_bit_cnt;
   logic [WORD_BITS-1:0]   r_shift;
   logic [WORD_BITS-1:0]   r_rx_shift;
   logic                   r_push_pend;
   logic                   r_skip;
   logic                   r_tx_underrun;
   logic                   r_rx_overflow;

   logic                   w_tx_wr;
   logic [WORD_BITS-1:0]   w_tx_head;
   logic                   w_tx_full;
   logic                   w_tx_empty;
   logic                   w_rx_full;
   logic                   w_rx_empty;

   // Reset values match the idle bus so that releasing reset cannot fake an edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
         r_ssel_sync <= '1;
         r_mosi_sync <= '0;
         r_sck_d     <= SCK_IDLE;
      end else begin
         r_sck_sync[0]  <= i_sck;
         r_ssel_sync[0] <= i_ssel_n;
         r_mosi_sync[0] <= i_mosi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sck_sync[i]  <= r_sck_sync[i-1];
            r_ssel_sync[i] <= r_ssel_sync[i-1];
            r_mosi_sync[i] <= r_mosi_sync[i-1];
         end
         r_sck_d <= w_sck;
      end
   end

   assign w_sck    = r_sck_sync[SYNC_STAGES-1];
   assign w_ssel_n = r_ssel_sync[SYNC_STAGES-1];
   assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];

   assign w_rise  = w_sck && !r_sck_d;
   assign w_fall  = !w_sck && r_sck_d;
   assign w_lead  = (CPOL == CPOL_IDLE_LOW) ? w_rise : w_fall;
   assign w_trail = (CPOL == CPOL_IDLE_LOW) ? w_fall : w_rise;

   assign w_sample_edge = (r_state == ST_SHIFT) && ((CPHA == CPHA_LEADING) ? w_lead : w_trail);
   assign w_shift_edge  = (r_state == ST_SHIFT) && ((CPHA == CPHA_LEADING) ? w_trail : w_lead);
   assign w_wrap        = w_sample_edge && (r_bit_cnt == CNT_MAX);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (!w_ssel_n) w_state_nxt = ST_LOAD;
         ST_LOAD:  w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (w_ssel_n) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Word reload rides on the same cycle as the RX push, while the frame stays selected.
   assign w_load = (r_state == ST_LOAD) ||
                   ((r_state == ST_SHIFT) && r_push_pend && (w_state_nxt == ST_SHIFT));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_bit_cnt     <= '0;
         r_shift       <= '1;
         r_rx_shift    <= '0;
         r_push_pend   <= 1'b0;
         r_skip        <= 1'b0;
         r_tx_underrun <= 1'b0;
         r_rx_overflow <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_push_pend   <= w_wrap;
         r_tx_underrun <= w_load && w_tx_empty;
         r_rx_overflow <= r_push_pend && w_rx_full && !i_rx_ready;

         if (r_state != ST_SHIFT) begin
            r_bit_cnt <= '0;
         end else if (w_sample_edge) begin
            r_bit_cnt  <= (r_bit_cnt == CNT_MAX) ? '0 : r_bit_cnt + CW'(1);
            r_rx_shift <= {r_rx_shift[WORD_BITS-2:0], w_mosi};
         end

         // A mid-frame reload lands before the next shift edge, which must not eat its MSB.
         if (w_load) begin
            r_shift <= w_tx_empty ? '1 : w_tx_head;
            r_skip  <= (r_state == ST_LOAD) ? (CPHA == CPHA_TRAILING) : 1'b1;
         end else if (w_shift_edge) begin
            if (r_skip) r_skip  <= 1'b0;
            else        r_shift <= {r_shift[WORD_BITS-2:0], 1'b1};
         end else if (r_state == ST_IDLE) begin
            r_shift <= '1;
            r_skip  <= 1'b0;
         end
      end
   end

   assign w_tx_wr = i_tx_valid && !w_tx_full;

   sync_fifo #(.WIDTH(WORD_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr_en   (w_tx_wr),
      .i_wr_data (i_tx_data),
      .i_rd_en   (w_load),
      .o_rd_data (w_tx_head),
      .o_full    (w_tx_full),
      .o_empty   (w_tx_empty)
   );

   sync_fifo #(.WIDTH(WORD_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr_en   (r_push_pend),
      .i_wr_data (r_rx_shift),
      .i_rd_en   (i_rx_ready),
      .o_rd_data (o_rx_data),
      .o_full    (w_rx_full),
      .o_empty   (w_rx_empty)
   );

   assign o_tx_ready    = !w_tx_full;
   assign o_rx_valid    = !w_rx_empty;
   assign o_busy        = (r_state == ST_SHIFT);
   assign o_miso_oe     = (r_state == ST_SHIFT);
   assign o_miso        = r_shift[WORD_BITS-1];
   assign o_tx_underrun = r_tx_underrun;
   assign o_rx_overflow = r_rx_overflow;
   assign o_dbg_state   = r_state;

endmodule
